// File: rtl/irrigation_scheduler.sv
// irrigation_scheduler
//   Decides when to water and with which actuator (splinker or dripper),
//   times the run and soak phases on a tick timebase, limits the number of
//   run phases per watering demand, and locks out while the tank is low.
//
//   Optional feature macro: IRRIGATION_MANUAL_EN
//     When defined, adds manual_req / manual_sel so an operator can start a
//     single run phase from IDLE regardless of soil moisture.
//
// Ports
//   clk, rst_n        system clock (rising edge), async active-low reset
//   tick              single-cycle timebase enable for the phase timer
//   soil_dry          soil moisture below threshold (watering demand)
//   air_dry           low air humidity; selects splinker instead of dripper
//   tank_low          water level too low; forces LOCKOUT from IDLE/RUN/SOAK
//   fault_clr         acknowledge that leaves FAULT
//   manual_req/_sel   (IRRIGATION_MANUAL_EN only) manual run, 1=splinker
//   irrigation_on     watering active (RUN)
//   splinker_on       splinker driven during RUN
//   dripper_on        dripper driven during RUN
//   error             FAULT state
//   state             current state code, also the debug view of the FSM
module irrigation_scheduler #(
    parameter int RUN_TICKS  = 10,
    parameter int SOAK_TICKS = 5,
    parameter int MAX_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       soil_dry,
    input  logic       air_dry,
    input  logic       tank_low,
    input  logic       fault_clr,
`ifdef IRRIGATION_MANUAL_EN
    input  logic       manual_req,
    input  logic       manual_sel,
`endif
    output logic       irrigation_on,
    output logic       splinker_on,
    output logic       dripper_on,
    output logic       error,
    output logic [2:0] state
);

    localparam int TMAX = (RUN_TICKS > SOAK_TICKS) ? RUN_TICKS : SOAK_TICKS;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int CW   = $clog2(MAX_CYCLES + 1);

    localparam logic [TW-1:0] RUN_LOAD  = TW'(RUN_TICKS);
    localparam logic [TW-1:0] SOAK_LOAD = TW'(SOAK_TICKS);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);
    localparam logic [CW-1:0] CYC_MAX   = CW'(MAX_CYCLES);

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        RUN     = 3'b001,
        SOAK    = 3'b010,
        LOCKOUT = 3'b011,
        FAULT   = 3'b100
    } state_t;

    state_t        cur, nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [CW-1:0] cycles, cycles_nxt;
    logic          mode, mode_nxt;        // 1 = splinker, 0 = dripper
    logic          manual, manual_nxt;    // current demand came from manual_req
    logic          last_tick;

    // The phase ends on the tick that would take the timer from 1 to 0.
    assign last_tick = tick && (timer == TIMER_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur    <= IDLE;
            timer  <= '0;
            cycles <= '0;
            mode   <= 1'b0;
            manual <= 1'b0;
        end else begin
            cur    <= nxt;
            timer  <= timer_nxt;
            cycles <= cycles_nxt;
            mode   <= mode_nxt;
            manual <= manual_nxt;
        end
    end

    always_comb begin
        nxt        = cur;
        timer_nxt  = timer;
        cycles_nxt = cycles;
        mode_nxt   = mode;
        manual_nxt = manual;
        case (cur)
            IDLE: begin
                cycles_nxt = '0;
                manual_nxt = 1'b0;
                if (tank_low) begin
                    nxt = LOCKOUT;
`ifdef IRRIGATION_MANUAL_EN
                end else if (manual_req) begin
                    // Manual wins over an automatic demand in the same cycle.
                    nxt        = RUN;
                    mode_nxt   = manual_sel;
                    manual_nxt = 1'b1;
                    timer_nxt  = RUN_LOAD;
`endif
                end else if (soil_dry) begin
                    nxt       = RUN;
                    mode_nxt  = air_dry;
                    timer_nxt = RUN_LOAD;
                end
            end
            RUN: begin
                // tank_low outranks timer expiry in the same cycle.
                if (tank_low) begin
                    nxt = LOCKOUT;
                end else if (last_tick) begin
                    nxt       = SOAK;
                    timer_nxt = SOAK_LOAD;
                    if (cycles != CYC_MAX) cycles_nxt = cycles + CW'(1);
                end else if (tick && timer != '0) begin
                    timer_nxt = timer - TIMER_ONE;
                end
            end
            SOAK: begin
                if (tank_low) begin
                    nxt = LOCKOUT;
                end else if (last_tick) begin
                    timer_nxt = '0;
                    if (!soil_dry || manual) begin
                        nxt = IDLE;
                    end else if (cycles == CYC_MAX) begin
                        nxt = FAULT;
                    end else begin
                        nxt       = RUN;
                        mode_nxt  = air_dry;
                        timer_nxt = RUN_LOAD;
                    end
                end else if (tick && timer != '0) begin
                    timer_nxt = timer - TIMER_ONE;
                end
            end
            LOCKOUT: begin
                cycles_nxt = '0;
                timer_nxt  = '0;
                manual_nxt = 1'b0;
                if (!tank_low) nxt = IDLE;
            end
            FAULT: begin
                if (fault_clr) nxt = IDLE;
            end
            default: begin
                // Unused codes fall back to a clean IDLE.
                nxt        = IDLE;
                timer_nxt  = '0;
                cycles_nxt = '0;
                manual_nxt = 1'b0;
            end
        endcase
    end

    // Outputs decode directly from flops, so an async reset clears them at once.
    assign state         = cur;
    assign irrigation_on = (cur == RUN);
    assign splinker_on   = (cur == RUN) &&  mode;
    assign dripper_on    = (cur == RUN) && !mode;
    assign error         = (cur == FAULT);

endmodule

// File: tb/tb_irrigation_scheduler.sv
module tb_irrigation_scheduler;

    localparam int RUN_T  = 3;
    localparam int SOAK_T = 2;
    localparam int MAX_C  = 2;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic tick = 1'b0, soil_dry = 1'b0, air_dry = 1'b0, tank_low = 1'b0, fault_clr = 1'b0;
`ifdef IRRIGATION_MANUAL_EN
    logic manual_req = 1'b0, manual_sel = 1'b0;
`endif
    logic       irrigation_on, splinker_on, dripper_on, error;
    logic [2:0] state;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    bit started = 1'b0;

    irrigation_scheduler #(.RUN_TICKS(RUN_T), .SOAK_TICKS(SOAK_T), .MAX_CYCLES(MAX_C)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .soil_dry(soil_dry), .air_dry(air_dry),
        .tank_low(tank_low), .fault_clr(fault_clr),
`ifdef IRRIGATION_MANUAL_EN
        .manual_req(manual_req), .manual_sel(manual_sel),
`endif
        .irrigation_on(irrigation_on), .splinker_on(splinker_on), .dripper_on(dripper_on),
        .error(error), .state(state)
    );

    // Behavioural model: phase name as spec code, ticks remaining in the
    // phase, and the number of completed watering phases for this demand.
    int m_phase  = 0;
    int m_left   = 0;
    int m_runs   = 0;
    bit m_spl    = 1'b0;
    bit m_manual = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_left = 0; m_runs = 0; m_spl = 1'b0; m_manual = 1'b0;
        end else begin
            if (m_phase == 0) begin
                m_runs = 0;
                m_manual = 1'b0;
                if (tank_low) m_phase = 3;
`ifdef IRRIGATION_MANUAL_EN
                else if (manual_req) begin
                    m_phase = 1; m_spl = manual_sel; m_manual = 1'b1; m_left = RUN_T;
                end
`endif
                else if (soil_dry) begin
                    m_phase = 1; m_spl = air_dry; m_left = RUN_T;
                end
            end else if (m_phase == 1 || m_phase == 2) begin
                if (tank_low) m_phase = 3;
                else if (tick) begin
                    m_left = m_left - 1;
                    if (m_left == 0 && m_phase == 1) begin
                        m_runs = (m_runs < MAX_C) ? m_runs + 1 : MAX_C;
                        m_phase = 2; m_left = SOAK_T;
                    end else if (m_left == 0) begin
                        if (!soil_dry || m_manual) m_phase = 0;
                        else if (m_runs >= MAX_C) m_phase = 4;
                        else begin
                            m_phase = 1; m_spl = air_dry; m_left = RUN_T;
                        end
                    end
                end
            end else if (m_phase == 3) begin
                m_runs = 0;
                if (!tank_low) m_phase = 0;
            end else begin
                if (fault_clr) m_phase = 0;
            end
        end
    end

    // Compare process: every cycle once out of the initial reset.
    always @(negedge clk) begin
        logic [6:0] exp_v, act_v;
        if (started) begin
            exp_v = {m_phase == 1, m_phase == 1 && m_spl, m_phase == 1 && !m_spl,
                     m_phase == 4, 3'(m_phase)};
            act_v = {irrigation_on, splinker_on, dripper_on, error, state};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL model_cmp t=%0t act=%b exp=%b", $time, act_v, exp_v);
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        tick = (cyc % 4 == 0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Steps until the FSM reaches target; records distinct state codes as octal digits.
    task automatic record_until(input logic [2:0] target, input logic [2:0] start,
                                output logic [31:0] seq);
        logic [2:0] last;
        int g;
        last = start; seq = 0; g = 0;
        while (state !== target && g < 300) begin
            step();
            if (state !== last) begin
                seq = seq * 8 + 32'(state);
                last = state;
            end
            g++;
        end
    endtask

    initial begin
        int n, g;
        logic [31:0] seq;

        #1 rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        started = 1'b1;
        chk("reset_outputs", {irrigation_on, splinker_on, dripper_on, error, state}, 0);
        step();
        chk("idle_hold", 32'(state), 0);

        // Dripper cycle
        soil_dry = 1'b1; air_dry = 1'b0;
        step();
        chk("drip_enter_run", 32'(state), 1);
        chk("drip_actuators", {irrigation_on, splinker_on, dripper_on}, 3'b101);
        n = 0; g = 0;
        while (state === 3'd1 && g < 100) begin if (tick) n++; step(); g++; end
        chk("drip_run_ticks", n, RUN_T);
        chk("drip_to_soak", 32'(state), 2);
        soil_dry = 1'b0;
        n = 0; g = 0;
        while (state === 3'd2 && g < 100) begin if (tick) n++; step(); g++; end
        chk("drip_soak_ticks", n, SOAK_T);
        chk("drip_back_idle", 32'(state), 0);
        repeat (3) step();

        // Fault path
        soil_dry = 1'b1; air_dry = 1'b1;
        step();
        chk("spl_actuators", {irrigation_on, splinker_on, dripper_on}, 3'b110);
        record_until(3'd4, 3'd1, seq);
        chk("fault_sequence", seq, 32'o2124);
        chk("fault_outputs", {irrigation_on, splinker_on, dripper_on, error}, 4'b0001);
        tank_low = 1'b1;
        step();
        tank_low = 1'b0;
        chk("fault_ignores_tank", 32'(state), 4);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        chk("fault_clr_idle", 32'(state), 0);
        step();
        chk("rerun_after_clr", 32'(state), 1);

        // Interlock on the final RUN tick
        n = 0; g = 0;
        while (state === 3'd1 && g < 100) begin
            if (tick) begin
                if (n == RUN_T - 1) begin tank_low = 1'b1; step(); break; end
                n++;
            end
            step(); g++;
        end
        chk("lockout_state", 32'(state), 3);
        chk("lockout_irr", 32'(irrigation_on), 0);
        repeat (2) step();
        tank_low = 1'b0;
        step();
        chk("lockout_release", 32'(state), 0);
        step();
        chk("lockout_rerun", 32'(state), 1);
        record_until(3'd4, 3'd1, seq);
        chk("cycles_restarted", seq, 32'o2124);

        // Async reset mid-RUN
        fault_clr = 1'b1; air_dry = 1'b0;
        step();
        fault_clr = 1'b0;
        step();
        repeat (2) step();
        chk("pre_reset_run", {irrigation_on, dripper_on}, 2'b11);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", {irrigation_on, splinker_on, dripper_on, error, state}, 0);
        soil_dry = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("post_reset_idle", 32'(state), 0);

`ifdef IRRIGATION_MANUAL_EN
        manual_req = 1'b1; manual_sel = 1'b1; soil_dry = 1'b0;
        step();
        manual_req = 1'b0;
        chk("manual_run", {irrigation_on, splinker_on, dripper_on}, 3'b110);
        n = 0; g = 0;
        while (state === 3'd1 && g < 100) begin if (tick) n++; step(); g++; end
        chk("manual_ticks", n, RUN_T);
        chk("manual_soak", 32'(state), 2);
        soil_dry = 1'b1;
        g = 0;
        while (state === 3'd2 && g < 100) begin step(); g++; end
        chk("manual_idle", {error, state}, 0);
        soil_dry = 1'b0;
        step();
`endif

        repeat (4) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irrigation_scheduler.md
# irrigation_scheduler

Sequences the irrigation actuators from sensor conditions: decides when to water and whether to use the splinker or the dripper, times run and soak phases, and enforces a water-tank interlock. Its `irrigation_on`, `splinker_on` and `dripper_on` outputs drive the irrigation encoder and the actuator outputs. Its `state` and `error` outputs feed the status display.

## Interface
- `RUN_TICKS`, 10: ticks per watering phase (≥1)
- `SOAK_TICKS`, 5: ticks of pause between phases (≥1)
- `MAX_CYCLES`, 3: run phases allowed per demand before fault (≥1)
- `clk` in 1: system clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `tick` in 1: single-cycle timebase enable; phase timers count only on `tick`
- `soil_dry` in 1: soil moisture below threshold
- `air_dry` in 1: air humidity low; selects splinker
- `tank_low` in 1: water level too low to irrigate
- `fault_clr` in 1: single-cycle fault acknowledge
- `irrigation_on` out 1: watering active
- `splinker_on` out 1: splinker selected
- `dripper_on` out 1: dripper selected
- `error` out 1: FAULT state
- `state` out 3: current state code

## Operation
- States: IDLE=000, RUN=001, SOAK=010, LOCKOUT=011, FAULT=100. Codes 101–111 are unreachable and recover to IDLE.
- IDLE behaviour:
  - All actuator outputs are 0 and `cycles`=0.
  - If `tank_low`, go to LOCKOUT.
  - Else if `soil_dry`, go to RUN. Latch mode: splinker if `air_dry`, else dripper. Load timer with RUN_TICKS.
- RUN behaviour:
  - `irrigation_on`=1. Exactly one of `splinker_on`/`dripper_on`=1, per the latched mode. Mode is frozen for the whole phase.
  - Each `tick` decrements the timer.
  - On a `tick` with timer==1: `cycles`++, load SOAK_TICKS, go to SOAK.
  - `soil_dry` falling during RUN has no effect; the phase completes.
- SOAK behaviour:
  - All actuator outputs are 0.
  - On a `tick` with timer==1:
    - `!soil_dry`: go to IDLE.
    - `soil_dry` and `cycles`==MAX_CYCLES: go to FAULT.
    - Otherwise: go to RUN, re-latching mode from `air_dry`.
- LOCKOUT behaviour:
  - All actuator outputs are 0; `cycles` is cleared.
  - When `!tank_low`, go to IDLE.
- FAULT behaviour:
  - `error`=1 and actuators are 0.
  - Only `fault_clr` (or reset) exits, to IDLE.
  - `fault_clr` in any other state is ignored.
- Priority: `tank_low` in RUN or SOAK forces LOCKOUT and overrides timer expiry in the same cycle. FAULT ignores `tank_low`.
- Timer width is `$clog2(max(RUN_TICKS,SOAK_TICKS)+1)`. `cycles` width is `$clog2(MAX_CYCLES+1)`. Neither wraps.

## Timing
- All outputs are registered and decoded from state plus the latched mode. They change one `clk` after the qualifying input sample.
- IDLE→RUN latency is 1 cycle and does not wait for `tick`.
- A RUN phase lasts exactly RUN_TICKS `tick` pulses. It ends on the cycle after the RUN_TICKS-th pulse, measured from entry.
- `tick` held high counts once per cycle.
- Reset values: state=IDLE, timer=0, `cycles`=0, mode=dripper, all outputs 0.
- Reset asserted mid-RUN drops the actuators immediately, without waiting for a clock edge.

## Configuration
- `IRRIGATION_MANUAL_EN` defined:
  - Adds inputs `manual_req` (1) and `manual_sel` (1; 1=splinker).
  - In IDLE with `!tank_low`, `manual_req` starts one RUN with mode=`manual_sel` regardless of `soil_dry`.
  - Manual has priority over automatic in the same cycle.
  - The following SOAK always returns to IDLE, and a manual run never causes FAULT.
- `IRRIGATION_MANUAL_EN` undefined: the ports are absent and behaviour is automatic only.

## Test plan
Bench parameters: RUN_TICKS=3, SOAK_TICKS=2, MAX_CYCLES=2; `tick` every 4th cycle.
- Dripper cycle: `soil_dry`=1, `air_dry`=0.
  - Required: `irrigation_on`=`dripper_on`=1 and `splinker_on`=0 for exactly 3 ticks, then state=010 for 2 ticks.
  - Drop `soil_dry` in SOAK -> state=000.
- Fault: `soil_dry` held at 1 with `air_dry`=1.
  - Required: sequence RUN, SOAK, RUN, SOAK, then state=100 and `error`=1 with actuators 0.
  - Pulse `fault_clr` -> IDLE next cycle, then RUN again.
- Interlock: assert `tank_low` on the same cycle as the final RUN tick.
  - Required: state=011 next cycle and `irrigation_on`=0.
  - Release `tank_low` -> IDLE, then RUN with `cycles` restarted.
- Async reset: pull `rst_n` low between clock edges mid-RUN -> all outputs 0 before the next edge; state=000 after release.
- Manual, with `IRRIGATION_MANUAL_EN` defined:
  - Setup: `soil_dry`=0, `manual_req`=1, `manual_sel`=1.
  - Required: `splinker_on`=1 for 3 ticks, SOAK, then IDLE with no FAULT.
